// File: rtl/burst_ram_pkg.sv
// Command and FSM state encodings shared by the burst RAM block.
// No logic lives here; only the types that decode and control use.
package burst_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/burst_ram_array.sv
// Storage: one write port, one registered read port, contents never reset.
// Latency: read data valid one edge after re; no backpressure (always accepts).
// Same-address write and read on one edge returns the old word.
module burst_ram_array
    import burst_ram_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [MEM_WIDTH-1:0]  wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [MEM_WIDTH-1:0]  rdata
);

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/burst_ram.sv
// Command-driven RAM: address/data commands on din, read words out on dout.
// Latency: one cycle from accepted read command to tx_valid/dout.
// Backpressure: read word held until tx_ready; reads arriving while held are dropped and flagged.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int MEM_DEPTH    = 256,
    parameter int MEM_WIDTH    = 8,
    parameter int AUTO_INC     = 1,
    parameter int TX_HANDSHAKE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MEM_WIDTH+1:0] din,
    input  logic                 rx_valid,
    input  logic                 tx_ready,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic                 rd_ovf
);

    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    if (MEM_DEPTH < 2 || ADDR_WIDTH > MEM_WIDTH) begin : g_param_chk
        $error("burst_ram: need MEM_DEPTH >= 2 and $clog2(MEM_DEPTH) <= MEM_WIDTH");
    end

    // Low address bits are below 2*MEM_DEPTH, so one conditional subtract is a full modulo.
    function automatic logic [ADDR_WIDTH-1:0] fold(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= DEPTH_EXT) ? a - DEPTH_EXT[ADDR_WIDTH-1:0] : a;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    cmd_e                  cmd;
    logic [MEM_WIDTH-1:0]  payload;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [MEM_WIDTH-1:0]  rdata;
    state_e                state_q, state_d;
    logic                  have_data;
    logic                  rd_cmd, hs_done, rd_accept, rd_drop;

    assign cmd     = cmd_e'(din[MEM_WIDTH+1:MEM_WIDTH]);
    assign payload = din[MEM_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        rd_cmd    = rx_valid && (cmd == CMD_RD_DATA);
        hs_done   = (state_q == HOLD) && ((TX_HANDSHAKE == 0) || tx_ready);
        rd_accept = rd_cmd && ((state_q == IDLE) || hs_done);
        rd_drop   = rd_cmd && !rd_accept;
        case (state_q)
            IDLE:    if (rd_accept) state_d = HOLD;
            HOLD:    if (hs_done && !rd_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_addr   <= '0;
            rd_addr   <= '0;
            rd_ovf    <= 1'b0;
            have_data <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= fold(payload[ADDR_WIDTH-1:0]);
                    CMD_WR_DATA: if (AUTO_INC != 0) wr_addr <= next_addr(wr_addr);
                    CMD_RD_ADDR: rd_addr <= fold(payload[ADDR_WIDTH-1:0]);
                    CMD_RD_DATA: if (rd_accept && AUTO_INC != 0) rd_addr <= next_addr(rd_addr);
                    default: ;
                endcase
            end
            if (rd_accept) begin
                have_data <= 1'b1;
            end
            if (rd_drop) begin
                rd_ovf <= 1'b1;
            end
        end
    end

    burst_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .MEM_WIDTH (MEM_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (rx_valid && (cmd == CMD_WR_DATA)),
        .waddr(wr_addr),
        .wdata(payload),
        .re   (rd_accept),
        .raddr(rd_addr),
        .rdata(rdata)
    );

    // The array read register has no reset, so dout is gated until a word has been read.
    assign dout     = have_data ? rdata : '0;
    assign tx_valid = (state_q == HOLD);

endmodule

// File: tb/tb_burst_ram.sv
// Bench for burst_ram: default, 200-deep, no-increment and pulse-mode instances
// share one command bus; each sequence checks only the instance it targets.
module tb_burst_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b0;

    logic [7:0] dout, dout_w, dout_n, dout_p;
    logic       vld, vld_w, vld_n, vld_p;
    logic       ovf, ovf_w, ovf_n, ovf_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    burst_ram dut (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout), .tx_valid(vld), .rd_ovf(ovf)
    );

    burst_ram #(.MEM_DEPTH(200)) dut_w (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout_w), .tx_valid(vld_w), .rd_ovf(ovf_w)
    );

    burst_ram #(.AUTO_INC(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout_n), .tx_valid(vld_n), .rd_ovf(ovf_n)
    );

    burst_ram #(.TX_HANDSHAKE(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout_p), .tx_valid(vld_p), .rd_ovf(ovf_p)
    );

    typedef struct {
        logic       rv;
        logic [1:0] cmd;
        logic [7:0] pay;
        logic       trdy;
        logic       e_vld;
        logic [7:0] e_dout;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rv, input logic [1:0] c, input logic [7:0] p,
                                input logic tr, input logic ev, input logic [7:0] ed,
                                input logic eo);
        vec_t r;
        r.rv = rv; r.cmd = c; r.pay = p; r.trdy = tr;
        r.e_vld = ev; r.e_dout = ed; r.e_ovf = eo;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rv, input logic [1:0] c, input logic [7:0] p, input logic tr);
        rx_valid = rv;
        din      = {c, p};
        tx_ready = tr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rv cmd pay trdy | tx_valid dout rd_ovf
        tbl.push_back(mk(1, 2'd0, 8'h10, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 2'd1, 8'hA1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 2'd1, 8'hA2, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 2'd1, 8'hA3, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 2'd2, 8'h10, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 2'd3, 8'h00, 1, 1, 8'hA1, 0));
        tbl.push_back(mk(0, 2'd0, 8'h00, 1, 0, 8'hA1, 0));
        tbl.push_back(mk(1, 2'd3, 8'h00, 1, 1, 8'hA2, 0));
        tbl.push_back(mk(0, 2'd0, 8'h00, 1, 0, 8'hA2, 0));
        tbl.push_back(mk(1, 2'd3, 8'h00, 1, 1, 8'hA3, 0));
        tbl.push_back(mk(0, 2'd0, 8'h00, 1, 0, 8'hA3, 0));
        tbl.push_back(mk(1, 2'd1, 8'hA4, 1, 0, 8'hA3, 0));   // MEM[0x13]
        tbl.push_back(mk(1, 2'd2, 8'h11, 0, 0, 8'hA3, 0));
        tbl.push_back(mk(1, 2'd3, 8'h00, 0, 1, 8'hA2, 0));   // held, rd_addr -> 0x12
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 2'd0, 8'h00, 0, 1, 8'hA2, 0));
        tbl.push_back(mk(1, 2'd3, 8'h00, 0, 1, 8'hA2, 1));   // dropped
        tbl.push_back(mk(0, 2'd0, 8'h00, 1, 0, 8'hA2, 1));
        tbl.push_back(mk(1, 2'd3, 8'h00, 1, 1, 8'hA3, 1));   // still 0x12 after drop
        tbl.push_back(mk(1, 2'd3, 8'h00, 1, 1, 8'hA4, 1));   // accepted on handshake cycle
        tbl.push_back(mk(1, 2'd0, 8'h13, 0, 1, 8'hA4, 1));
        tbl.push_back(mk(1, 2'd1, 8'hEE, 0, 1, 8'hA4, 1));   // write to held address
        tbl.push_back(mk(0, 2'd0, 8'h00, 1, 0, 8'hA4, 1));
        tbl.push_back(mk(1, 2'd2, 8'h13, 1, 0, 8'hA4, 1));
        tbl.push_back(mk(1, 2'd3, 8'h00, 1, 1, 8'hEE, 1));
        tbl.push_back(mk(0, 2'd0, 8'h00, 1, 0, 8'hEE, 1));
        tbl.push_back(mk(1, 2'd2, 8'h10, 1, 0, 8'hEE, 1));
        tbl.push_back(mk(1, 2'd3, 8'h00, 0, 1, 8'hA1, 1));   // leave in HOLD for reset test

        repeat (2) @(posedge clk);
        #1;
        chk("reset tx_valid", {7'd0, vld}, 8'h00);
        chk("reset dout", dout, 8'h00);
        chk("reset rd_ovf", {7'd0, ovf}, 8'h00);
        chk("reset tx_valid_w", {7'd0, vld_w}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].rv, tbl[i].cmd, tbl[i].pay, tbl[i].trdy);
            chk($sformatf("vec%0d tx_valid", i), {7'd0, vld}, {7'd0, tbl[i].e_vld});
            chk($sformatf("vec%0d dout", i), dout, tbl[i].e_dout);
            chk($sformatf("vec%0d rd_ovf", i), {7'd0, ovf}, {7'd0, tbl[i].e_ovf});
        end

        // Asynchronous reset while holding a word, between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("async rst tx_valid", {7'd0, vld}, 8'h00);
        chk("async rst dout", dout, 8'h00);
        chk("async rst rd_ovf", {7'd0, ovf}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 2'd0, 8'h00, 1);
        chk("post rst tx_valid", {7'd0, vld}, 8'h00);
        step(1, 2'd2, 8'h10, 1);
        step(1, 2'd3, 8'h00, 1);
        chk("post rst mem kept", dout, 8'hA1);
        chk("post rst tx_valid rd", {7'd0, vld}, 8'h01);
        step(0, 2'd0, 8'h00, 1);

        // 200-deep instance: wrap of both address counters, modulo on load.
        step(1, 2'd0, 8'hC7, 1);
        step(1, 2'd1, 8'h11, 1);
        step(1, 2'd1, 8'h22, 1);
        step(1, 2'd2, 8'hC7, 1);
        step(1, 2'd3, 8'h00, 1);
        chk("wrap mem199", dout_w, 8'h11);
        chk("wrap tx_valid", {7'd0, vld_w}, 8'h01);
        step(0, 2'd0, 8'h00, 1);
        step(1, 2'd3, 8'h00, 1);
        chk("wrap rd mem0", dout_w, 8'h22);
        step(0, 2'd0, 8'h00, 1);
        step(1, 2'd2, 8'hC8, 1);
        step(1, 2'd3, 8'h00, 1);
        chk("modulo load 200", dout_w, 8'h22);
        step(0, 2'd0, 8'h00, 1);

        // No-increment instance.
        step(1, 2'd0, 8'h06, 1);
        step(1, 2'd1, 8'h77, 1);
        step(1, 2'd0, 8'h05, 1);
        step(1, 2'd1, 8'h55, 1);
        step(1, 2'd1, 8'h66, 1);
        step(1, 2'd2, 8'h05, 1);
        step(1, 2'd3, 8'h00, 1);
        chk("noinc mem5", dout_n, 8'h66);
        chk("noinc tx_valid", {7'd0, vld_n}, 8'h01);
        step(0, 2'd0, 8'h00, 1);
        step(1, 2'd3, 8'h00, 1);
        chk("noinc rd_addr held", dout_n, 8'h66);
        step(0, 2'd0, 8'h00, 1);
        step(1, 2'd2, 8'h06, 1);
        step(1, 2'd3, 8'h00, 1);
        chk("noinc mem6 untouched", dout_n, 8'h77);
        chk("noinc rd_ovf", {7'd0, ovf_n}, 8'h00);
        step(0, 2'd0, 8'h00, 1);

        // Pulse-mode instance: tx_valid lasts one cycle even with tx_ready low.
        step(1, 2'd2, 8'h10, 0);
        step(1, 2'd3, 8'h00, 0);
        chk("pulse tx_valid", {7'd0, vld_p}, 8'h01);
        chk("pulse dout", dout_p, 8'hA1);
        step(0, 2'd0, 8'h00, 0);
        chk("pulse tx_valid drop", {7'd0, vld_p}, 8'h00);
        chk("pulse rd_ovf", {7'd0, ovf_p}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, number of words (any value >= 2, not restricted to powers of two).
REQ-002 The block SHALL have parameter MEM_WIDTH, default 8, word width in bits.
REQ-003 The block SHALL have parameter AUTO_INC, default 1; when 1, the address increments after every data access.
REQ-004 The block SHALL have parameter TX_HANDSHAKE, default 1; when 1, read data is held until tx_ready; when 0, tx_valid is a single-cycle pulse.
REQ-005 The block SHALL have derived localparam ADDR_WIDTH = $clog2(MEM_DEPTH), and SHALL require ADDR_WIDTH <= MEM_WIDTH, checked at elaboration.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port din, input, MEM_WIDTH+2 bits: din[MEM_WIDTH+1:MEM_WIDTH] is the command and din[MEM_WIDTH-1:0] is the payload.
REQ-009 The block SHALL have port rx_valid, input, 1 bit: din is valid and is consumed on this cycle.
REQ-010 The block SHALL have port tx_ready, input, 1 bit: the consumer accepts dout.
REQ-011 The block SHALL have port dout, output, MEM_WIDTH bits: read data.
REQ-012 The block SHALL have port tx_valid, output, 1 bit: dout is valid.
REQ-013 The block SHALL have port rd_ovf, output, 1 bit: sticky flag indicating a read command was dropped.

Function
REQ-014 Command 00 (rx_valid=1) SHALL load wr_addr with payload[ADDR_WIDTH-1:0].
REQ-015 Command 01 SHALL write the payload to MEM[wr_addr], then increment wr_addr when AUTO_INC=1.
REQ-016 Command 10 SHALL load rd_addr with payload[ADDR_WIDTH-1:0].
REQ-017 Command 11 SHALL read MEM[rd_addr] into dout, then increment rd_addr when AUTO_INC=1.
REQ-018 An address payload >= MEM_DEPTH SHALL be reduced modulo MEM_DEPTH.
REQ-019 Address increment SHALL wrap from MEM_DEPTH-1 to 0, for both wr_addr and rd_addr.
REQ-020 wr_addr and rd_addr SHALL be independent registers; writing one never alters the other.
REQ-021 Read latency SHALL be one cycle: command 11 accepted at edge N gives dout and tx_valid=1 after edge N.
REQ-022 The FSM SHALL have exactly two states, IDLE and HOLD. A read in IDLE moves the FSM to HOLD.
REQ-023 With TX_HANDSHAKE=1, in HOLD, tx_valid SHALL stay 1 and dout SHALL stay stable until a cycle with tx_valid&tx_ready; the FSM then returns to IDLE and tx_valid drops on the next edge.
REQ-024 With TX_HANDSHAKE=0, the FSM SHALL return to IDLE on the next edge regardless of tx_ready.
REQ-025 Command 11 arriving in HOLD without a completing handshake on the same cycle SHALL be dropped: no read, rd_addr unchanged, rd_ovf set to 1.
REQ-026 Command 11 arriving on the handshake-completion cycle SHALL be accepted: new dout after that edge, FSM stays in HOLD.
REQ-027 Commands 00, 01 and 10 SHALL be accepted in any state without stalling.
REQ-028 A write to the held address while in HOLD SHALL NOT change dout.
REQ-029 rd_ovf SHALL be sticky and cleared only by reset.
REQ-030 When rx_valid=0, no state SHALL change except the HOLD handshake exit.

Reset
REQ-031 While rst_n=0, asynchronously: dout=0, tx_valid=0, rd_ovf=0, wr_addr=0, rd_addr=0, state=IDLE.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Reset asserted during HOLD SHALL discard the pending word; the first post-reset cycle SHALL be IDLE with tx_valid=0.

Structure
REQ-034 Package burst_ram_pkg SHALL hold the command enum (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the state enum (IDLE, HOLD).
REQ-035 Storage SHALL be a sub-module burst_ram_array (parametrised MEM_DEPTH/MEM_WIDTH, one write port, one registered read port, no reset); burst_ram holds decode, address counters, FSM and flags.

Verification
REQ-036 Burst write/read: write address 0x10, write 0xA1,0xA2,0xA3, read address 0x10, then three reads with tx_ready=1 -> dout 0xA1,0xA2,0xA3, each with a one-cycle tx_valid.
REQ-037 Wrap: MEM_DEPTH=200; write address 199, write 0x11,0x22 -> MEM[199]=0x11, MEM[0]=0x22; reading back from 199 gives the same.
REQ-038 Backpressure: read with tx_ready=0 for 5 cycles -> tx_valid and dout held constant; tx_ready=1 -> tx_valid drops after that edge.
REQ-039 Overflow: second read while HOLD with tx_ready=0 -> rd_ovf=1, rd_addr unchanged, dout keeps the first word.
REQ-040 AUTO_INC=0: two writes 0x55,0x66 at address 5 -> MEM[5]=0x66, MEM[6] untouched.
REQ-041 Reset mid-HOLD: assert rst_n=0 asynchronously -> tx_valid=0, dout=0, rd_ovf=0 immediately; memory data is retained.
